set_assoc_cache: RTL
====================

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width.
REQ-002 Parameter DATA_W, default 16, word width; byte offset bit addr_in[0] is ignored.
REQ-003 Parameter SETS, default 64, power of two, number of sets.
REQ-004 Parameter WORDS, default 8, power of two, words per block.
REQ-005 Address split SHALL be: offset = addr[log2(WORDS):1], index = next log2(SETS) bits, tag = remaining upper bits (defaults 3/6/6).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 req_valid  in  1  processor access this cycle.
REQ-009 wrt_cmd  in  1  1 = write, 0 = read; qualified by req_valid.
REQ-010 addr_in  in  ADDR_W  access address.
REQ-011 wr_data  in  DATA_W  write data.
REQ-012 data_out  out  DATA_W  read data of hit word.
REQ-013 hit  out  1  req_valid and tag match in a valid way.
REQ-014 fsm_busy  out  1  stall; miss pending or fill in progress.
REQ-015 mem_rd_en, mem_wr_en  out  1  memory read request / write-through strobe.
REQ-016 mem_addr  out  ADDR_W  memory address; mem_wdata out DATA_W write-through data.
REQ-017 mem_data_valid  in  1  returning read word valid; mem_rdata in DATA_W returning word, in request order.

Function
REQ-018 Organisation: 2-way set-associative, one valid bit, tag and WORDS data words per way, one LRU bit per set.
REQ-019 Lookup is combinational: hit and data_out are valid in the same cycle as req_valid; data_out is 0 when hit=0.
REQ-020 Read hit: no state change except LRU := other way.
REQ-021 Write hit: word in the hit way is written at the clock edge; same cycle mem_wr_en=1, mem_addr=addr_in, mem_wdata=wr_data; LRU := other way.
REQ-022 Miss (req_valid, no hit, state IDLE): fsm_busy=1 combinationally that cycle; FSM latches the block address and victim way, enters FILL.
REQ-023 Victim: invalid way0, else invalid way1, else the way named by LRU.
REQ-024 FILL: mem_rd_en=1 for exactly WORDS consecutive cycles; mem_addr = {latched tag, index, req_cnt, 1'b0}, req_cnt 0..WORDS-1.
REQ-025 Each mem_data_valid in FILL writes mem_rdata to victim word ret_cnt, then ret_cnt increments; returns MAY overlap requests.
REQ-026 On the final return (ret_cnt=WORDS-1): write tag, valid=1, LRU := other way; next state IDLE; fsm_busy deasserts the next cycle.
REQ-027 After a fill the held request re-evaluates as a hit; write miss therefore completes as a write hit (write-allocate, write-through).
REQ-028 During FILL: hit=0, mem_wr_en=0, processor inputs ignored; mem_data_valid in IDLE is ignored.
REQ-029 Reads never drive mem_wr_en; mem_rd_en and mem_wr_en are never both 1.

Reset
REQ-030 rst low asynchronously: all valid and LRU bits 0, state IDLE, req_cnt=ret_cnt=0.
REQ-031 Reset in FILL SHALL abort the fill; no tag or valid written; data array contents are don't-care.
REQ-032 During and after reset with req_valid=0: fsm_busy, mem_rd_en, mem_wr_en, hit = 0.

Structure
REQ-033 Package cache_pkg holds the FSM state enum (IDLE, FILL) and the default parameter constants.
REQ-034 One sub-module, assoc_fill_fsm, owns state, req_cnt, ret_cnt and the latched miss address/victim; arrays and lookup stay in the top.

Verification
REQ-035 Cold read 0x1230 after reset -> fsm_busy=1, 8 mem reads 0x1230..0x123E, fill, then hit=1 with data_out = word returned for 0x1230.
REQ-036 Write 0xBEEF to 0x1232 after fill -> same cycle mem_wr_en=1, mem_addr=0x1232, mem_wdata=0xBEEF; later read 0x1232 hits with 0xBEEF.
REQ-037 Fill 0x0000, 0x0400 (same set 0); read 0x0000; access 0x0800 -> way holding 0x0400 evicted; 0x0000 still hits.
REQ-038 Write miss to 0x2004 -> fill 0x2000..0x200E, then one mem write 0x2004; no write before fill completes.
REQ-039 Memory with 4-cycle pipelined latency -> 8 requests in 8 consecutive cycles, fsm_busy low 1 cycle after 8th return.
REQ-040 rst pulsed low after 3 returns of a fill -> fsm_busy=0 immediately; re-access of same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and the fill FSM state type for the 2-way set-associative cache.
// Default geometry: 16-bit byte addresses, 16-bit words, 64 sets, 8 words per block.
package cache_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_SETS   = 64;
    localparam int DEF_WORDS  = 8;
    localparam int NUM_WAYS   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/assoc_fill_fsm.sv
// Miss handler: latches the missing block and victim way, issues WORDS consecutive
// memory reads and steers the returning words into the victim way.
module assoc_fill_fsm
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SETS   = DEF_SETS,
    parameter int WORDS  = DEF_WORDS,
    localparam int OFF_W = $clog2(WORDS),
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [TAG_W-1:0]  start_tag,
    input  logic [IDX_W-1:0]  start_idx,
    input  logic              start_way,
    input  logic              mem_data_valid,
    output logic              busy,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              fill_we,
    output logic [OFF_W-1:0]  fill_word,
    output logic              fill_done,
    output logic [TAG_W-1:0]  fill_tag,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              fill_way
);

    fill_state_t      state_reg, state_next;
    // Extra MSB on the request counter marks "all WORDS requests issued".
    logic [OFF_W:0]   req_cnt_reg, req_cnt_next;
    logic [OFF_W-1:0] ret_cnt_reg, ret_cnt_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             way_reg, way_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            req_cnt_reg <= '0;
            ret_cnt_reg <= '0;
            tag_reg     <= '0;
            idx_reg     <= '0;
            way_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_cnt_reg <= req_cnt_next;
            ret_cnt_reg <= ret_cnt_next;
            tag_reg     <= tag_next;
            idx_reg     <= idx_next;
            way_reg     <= way_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        req_cnt_next = req_cnt_reg;
        ret_cnt_next = ret_cnt_reg;
        tag_next     = tag_reg;
        idx_next     = idx_reg;
        way_next     = way_reg;
        rd_en        = 1'b0;
        fill_we      = 1'b0;
        fill_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = FILL;
                    req_cnt_next = '0;
                    ret_cnt_next = '0;
                    tag_next     = start_tag;
                    idx_next     = start_idx;
                    way_next     = start_way;
                end
            end
            FILL: begin
                if (!req_cnt_reg[OFF_W]) begin
                    rd_en        = 1'b1;
                    req_cnt_next = req_cnt_reg + 1'b1;
                end
                // Returns arrive in request order and may overlap outstanding requests.
                if (mem_data_valid) begin
                    fill_we      = 1'b1;
                    ret_cnt_next = ret_cnt_reg + 1'b1;
                    if (&ret_cnt_reg) begin
                        fill_done  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy      = (state_reg == FILL);
    assign rd_addr   = {tag_reg, idx_reg, req_cnt_reg[OFF_W-1:0], 1'b0};
    assign fill_word = ret_cnt_reg;
    assign fill_tag  = tag_reg;
    assign fill_idx  = idx_reg;
    assign fill_way  = way_reg;

endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative, write-allocate / write-through cache with combinational
// lookup; misses stall the processor while assoc_fill_fsm refills the victim block.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SETS   = DEF_SETS,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              wrt_cmd,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    output logic              fsm_busy,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 1 - OFF_W - IDX_W;

    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             unused_byte_bit;

    assign req_off         = addr_in[OFF_W:1];
    assign req_idx         = addr_in[OFF_W+IDX_W:OFF_W+1];
    assign req_tag         = addr_in[ADDR_W-1:OFF_W+IDX_W+1];
    assign unused_byte_bit = addr_in[0];

    logic              fill_busy;
    logic              fill_rd_en;
    logic [ADDR_W-1:0] fill_addr;
    logic              fill_we;
    logic [OFF_W-1:0]  fill_word;
    logic              fill_done;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic              fill_way;

    logic [NUM_WAYS-1:0] way_valid;
    logic [NUM_WAYS-1:0] way_match;
    logic [DATA_W-1:0]   way_word [NUM_WAYS];
    logic [SETS-1:0]     lru_reg;

    logic lookup_en;
    logic hit_way;
    logic wr_hit;
    logic miss_start;
    logic victim_way;

    // Lookup is suppressed while a fill is in flight so the held request stalls.
    assign lookup_en  = req_valid && !fill_busy;
    assign hit        = lookup_en && (|way_match);
    assign hit_way    = !way_match[0];
    assign wr_hit     = hit && wrt_cmd;
    assign miss_start = lookup_en && !(|way_match);
    assign victim_way = !way_valid[0] ? 1'b0 :
                        (!way_valid[1] ? 1'b1 : lru_reg[req_idx]);

    generate
        for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_way
            logic [SETS-1:0]   valid_reg;
            logic [TAG_W-1:0]  tag_mem  [SETS];
            logic [DATA_W-1:0] data_mem [SETS*WORDS];
            logic              fill_sel;
            logic              hit_sel;

            assign fill_sel = (fill_way == 1'(gi));
            assign hit_sel  = (hit_way == 1'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= '0;
                end else if (fill_done && fill_sel) begin
                    valid_reg[fill_idx] <= 1'b1;
                end
            end

            // Tag and data arrays carry no reset; only the valid bits gate their use.
            always_ff @(posedge clk) begin
                if (fill_done && fill_sel) begin
                    tag_mem[fill_idx] <= fill_tag;
                end
                if (fill_we && fill_sel) begin
                    data_mem[{fill_idx, fill_word}] <= mem_rdata;
                end else if (wr_hit && hit_sel) begin
                    data_mem[{req_idx, req_off}] <= wr_data;
                end
            end

            assign way_valid[gi] = valid_reg[req_idx];
            assign way_match[gi] = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
            assign way_word[gi]  = data_mem[{req_idx, req_off}];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_reg <= '0;
        end else if (fill_done) begin
            lru_reg[fill_idx] <= ~fill_way;
        end else if (hit) begin
            lru_reg[req_idx] <= ~hit_way;
        end
    end

    assoc_fill_fsm #(
        .ADDR_W (ADDR_W),
        .SETS   (SETS),
        .WORDS  (WORDS)
    ) u_fill_fsm (
        .clk            (clk),
        .rst            (rst),
        .start          (miss_start),
        .start_tag      (req_tag),
        .start_idx      (req_idx),
        .start_way      (victim_way),
        .mem_data_valid (mem_data_valid),
        .busy           (fill_busy),
        .rd_en          (fill_rd_en),
        .rd_addr        (fill_addr),
        .fill_we        (fill_we),
        .fill_word      (fill_word),
        .fill_done      (fill_done),
        .fill_tag       (fill_tag),
        .fill_idx       (fill_idx),
        .fill_way       (fill_way)
    );

    assign data_out  = hit ? way_word[hit_way] : '0;
    assign fsm_busy  = miss_start || fill_busy;
    assign mem_rd_en = fill_rd_en;
    assign mem_wr_en = wr_hit;
    assign mem_addr  = fill_busy ? fill_addr : addr_in;
    assign mem_wdata = wr_data;

endmodule
